axis_mm_controller: RTL and testbench



---
 rtl/axis_mm_controller.sv | 208 ++++++++++++++++++++
 tb/tb_axis_mm_controller.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mm_controller.sv
// axis_mm_controller: AXI-Stream front/back end for the matrix multiply coprocessor.
// Loads one input frame (A elements, then B elements) into A_RAM/B_RAM,
// pulses Start, waits for Done, then streams RES_RAM out with TLAST on the
// final result.
// Optional build macro TLAST_CHECK_EN: adds frame_err and aborts a frame
// whose TLAST arrives early; a missing TLAST is flagged but not aborted.
module axis_mm_controller #(
   parameter int width          = 8,
   parameter int A_depth_bits   = 3,
   parameter int B_depth_bits   = 2,
   parameter int RES_depth_bits = 1,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      S_AXIS_TVALID,
   output logic                      S_AXIS_TREADY,
   input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic                      S_AXIS_TLAST,
   output logic                      M_AXIS_TVALID,
   input  logic                      M_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic                      M_AXIS_TLAST,
   output logic                      A_write_en,
   output logic [A_depth_bits-1:0]   A_write_address,
   output logic [width-1:0]          A_write_data_in,
   output logic                      B_write_en,
   output logic [B_depth_bits-1:0]   B_write_address,
   output logic [width-1:0]          B_write_data_in,
   output logic                      Start,
   input  logic                      Done,
   output logic                      RES_read_en,
   output logic [RES_depth_bits-1:0] RES_read_address,
   input  logic [width-1:0]          RES_read_data_out
`ifdef TLAST_CHECK_EN
   ,
   output logic                      frame_err
`endif
);

   localparam int A_ELEMS   = 1 << A_depth_bits;
   localparam int B_ELEMS   = 1 << B_depth_bits;
   localparam int RES_ELEMS = 1 << RES_depth_bits;
   localparam int IN_TOTAL  = A_ELEMS + B_ELEMS;
   // Counters are one bit wider than strictly needed so the element totals fit.
   localparam int IN_W      = $clog2(IN_TOTAL + 1);
   localparam int OUT_W     = $clog2(RES_ELEMS + 1);

   localparam logic [IN_W-1:0]  A_ELEMS_C  = IN_W'(A_ELEMS);
   localparam logic [IN_W-1:0]  IN_LAST_C  = IN_W'(IN_TOTAL - 1);
   localparam logic [IN_W-1:0]  IN_ONE_C   = IN_W'(1);
   localparam logic [OUT_W-1:0] OUT_LAST_C = OUT_W'(RES_ELEMS - 1);
   localparam logic [OUT_W-1:0] OUT_ONE_C  = OUT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_INPUTS,
      S_COMPUTE,
      S_FETCH,
      S_LATCH,
      S_SEND
   } state_t;

   state_t                 state_q, state_d;
   logic [IN_W-1:0]        in_cnt_q, in_cnt_d;
   logic [OUT_W-1:0]       out_cnt_q, out_cnt_d;
   logic                   tready_q, tready_d;
   logic                   start_q, start_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
`ifdef TLAST_CHECK_EN
   logic                   ferr_q, ferr_d;
`endif

   logic                   in_hs;
   logic                   in_is_a;
   logic                   in_is_last;
   logic                   out_is_last;
   logic [IN_W-1:0]        b_off;
   logic                   unused_ok;

   // Upper TDATA bits carry nothing for this block; TLAST only matters with the check enabled.
   assign unused_ok   = ^{S_AXIS_TDATA, S_AXIS_TLAST};

   assign in_hs       = S_AXIS_TVALID & tready_q;
   assign in_is_a     = (in_cnt_q < A_ELEMS_C);
   assign in_is_last  = (in_cnt_q == IN_LAST_C);
   assign out_is_last = (out_cnt_q == OUT_LAST_C);
   assign b_off       = in_cnt_q - A_ELEMS_C;

   // Write strobes follow the input handshake directly; address/data are
   // forced to zero when no write is happening so idle outputs stay quiet.
   assign S_AXIS_TREADY    = tready_q;
   assign A_write_en       = in_hs & in_is_a;
   assign B_write_en       = in_hs & ~in_is_a;
   assign A_write_address  = A_write_en ? in_cnt_q[A_depth_bits-1:0] : '0;
   assign A_write_data_in  = A_write_en ? S_AXIS_TDATA[width-1:0] : '0;
   assign B_write_address  = B_write_en ? b_off[B_depth_bits-1:0] : '0;
   assign B_write_data_in  = B_write_en ? S_AXIS_TDATA[width-1:0] : '0;

   assign Start            = start_q;
   assign RES_read_en      = (state_q == S_FETCH);
   assign RES_read_address = RES_read_en ? out_cnt_q[RES_depth_bits-1:0] : '0;

   assign M_AXIS_TVALID    = (state_q == S_SEND);
   assign M_AXIS_TDATA     = tdata_q;
   assign M_AXIS_TLAST     = M_AXIS_TVALID & out_is_last;
`ifdef TLAST_CHECK_EN
   assign frame_err        = ferr_q;
`endif

   // Next-state and register-input logic for the load / compute / drain sequence.
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      tready_d  = tready_q;
      start_d   = 1'b0;
      tdata_d   = tdata_q;
`ifdef TLAST_CHECK_EN
      ferr_d    = ferr_q;
`endif
      case (state_q)
         S_IDLE, S_READ_INPUTS: begin
            // TREADY comes up on the first cycle after reset and stays up while loading.
            tready_d = 1'b1;
            if (in_hs) begin
               state_d = S_READ_INPUTS;
               if (in_is_last) begin
                  state_d  = S_COMPUTE;
                  in_cnt_d = '0;
                  tready_d = 1'b0;
                  start_d  = 1'b1;
`ifdef TLAST_CHECK_EN
                  if (!S_AXIS_TLAST) begin
                     ferr_d = 1'b1;
                  end
`endif
               end else begin
                  in_cnt_d = in_cnt_q + IN_ONE_C;
`ifdef TLAST_CHECK_EN
                  // Early TLAST: drop the partial frame and wait for a fresh one.
                  if (S_AXIS_TLAST) begin
                     in_cnt_d = '0;
                     state_d  = S_IDLE;
                     ferr_d   = 1'b1;
                  end
`endif
               end
            end
         end
         S_COMPUTE: begin
            if (Done) begin
               state_d   = S_FETCH;
               out_cnt_d = '0;
            end
         end
         S_FETCH: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            // RES_RAM data is valid one cycle after the read enable.
            tdata_d = DATA_WIDTH'(RES_read_data_out);
            state_d = S_SEND;
         end
         S_SEND: begin
            if (M_AXIS_TREADY) begin
               if (out_is_last) begin
                  state_d   = S_IDLE;
                  out_cnt_d = '0;
                  tready_d  = 1'b1;
               end else begin
                  state_d   = S_FETCH;
                  out_cnt_d = out_cnt_q + OUT_ONE_C;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counter and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         tready_q  <= 1'b0;
         start_q   <= 1'b0;
         tdata_q   <= '0;
`ifdef TLAST_CHECK_EN
         ferr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         tready_q  <= tready_d;
         start_q   <= start_d;
         tdata_q   <= tdata_d;
`ifdef TLAST_CHECK_EN
         ferr_q    <= ferr_d;
`endif
      end
   end

endmodule

// File: tb/tb_axis_mm_controller.sv
// Testbench for axis_mm_controller: behavioural RAMs, a Done responder,
// a frame-level reference model checked every cycle, and directed plus
// randomized frames.
module tb_axis_mm_controller;

   localparam int NA = 8;
   localparam int NB = 4;
   localparam int NR = 2;
   localparam int NT = NA + NB;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        S_AXIS_TVALID = 1'b0;
   logic        S_AXIS_TREADY;
   logic [31:0] S_AXIS_TDATA = '0;
   logic        S_AXIS_TLAST = 1'b0;
   logic        M_AXIS_TVALID;
   logic        M_AXIS_TREADY = 1'b0;
   logic [31:0] M_AXIS_TDATA;
   logic        M_AXIS_TLAST;
   logic        A_write_en;
   logic [2:0]  A_write_address;
   logic [7:0]  A_write_data_in;
   logic        B_write_en;
   logic [1:0]  B_write_address;
   logic [7:0]  B_write_data_in;
   logic        Start;
   logic        Done;
   logic        RES_read_en;
   logic [0:0]  RES_read_address;
   logic [7:0]  RES_read_data_out;
`ifdef TLAST_CHECK_EN
   logic        frame_err;
`endif

   always #5 clk = ~clk;

   axis_mm_controller dut (
      .clk(clk), .resetn(resetn),
      .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
      .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
      .A_write_en(A_write_en), .A_write_address(A_write_address),
      .A_write_data_in(A_write_data_in),
      .B_write_en(B_write_en), .B_write_address(B_write_address),
      .B_write_data_in(B_write_data_in),
      .Start(Start), .Done(Done),
      .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
      .RES_read_data_out(RES_read_data_out)
`ifdef TLAST_CHECK_EN
      , .frame_err(frame_err)
`endif
   );

   // ---------------- behavioural RAMs and Done responder ----------------
   logic [7:0] a_ram [NA];
   logic [7:0] b_ram [NB];
   logic [7:0] res_ram [NR];
   logic [7:0] res_rd = '0;
   logic [9:0] dsh = '0;
   logic       done_now = 1'b0;
   logic       spur = 1'b0;
   int         cyc = 0;

   always @(posedge clk) begin
      if (A_write_en) a_ram[A_write_address] <= A_write_data_in;
      if (B_write_en) b_ram[B_write_address] <= B_write_data_in;
      if (RES_read_en) res_rd <= res_ram[RES_read_address];
      dsh <= {dsh[8:0], Start};
      cyc <= cyc + 1;
   end
   assign RES_read_data_out = res_rd;
   assign Done = spur | (done_now ? Start : dsh[9]);

   // ---------------- scoring ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- frame-level reference model ----------------
   int          acc_cnt = 0;
   int          out_idx = 0;
   int          since_rst = 0;
   bit          busy = 0;
   bit          start_due = 0;
   bit          exp_ferr = 0;
   logic [7:0]  exp_res [NR];
   bit          prev_stall = 0;
   bit          prev_valid = 0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;
   int          last_out_hs = -100;
   int          final_hs_cyc = 0;
   int          start_cyc = 0;
   int          first_valid_cyc = 0;
   int          n_starts = 0;
   logic [31:0] got_d [$];
   bit          got_l [$];
   bit          hs_in, hs_out, fin;
   logic        rst_or;

   always @(negedge clk) begin
      if (!resetn) begin
         rst_or = |{S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST,
                    A_write_en, A_write_address, A_write_data_in,
                    B_write_en, B_write_address, B_write_data_in,
                    Start, RES_read_en, RES_read_address};
`ifdef TLAST_CHECK_EN
         rst_or = rst_or | frame_err;
`endif
         chk("reset_outputs_zero", rst_or, 0);
         acc_cnt = 0; out_idx = 0; since_rst = 0; busy = 0; start_due = 0;
         exp_ferr = 0; prev_stall = 0; prev_valid = 0; last_out_hs = -100;
      end else begin
         since_rst++;
         hs_in  = S_AXIS_TVALID && S_AXIS_TREADY;
         hs_out = M_AXIS_TVALID && M_AXIS_TREADY;
`ifdef TLAST_CHECK_EN
         chk("frame_err", frame_err, exp_ferr);
`endif
         if (since_rst >= 2) chk("s_tready", S_AXIS_TREADY, !busy);
         chk("start_pulse", Start, start_due);
         if (Start) begin start_cyc = cyc; n_starts++; end
         start_due = 0;

         if (RES_read_en) chk("res_read", {busy, RES_read_address}, {1'b1, 1'(out_idx)});

         if (prev_stall)
            chk("out_hold", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {1'b1, prev_last, prev_data});
         if (!busy) chk("m_valid_idle", M_AXIS_TVALID, 0);
         else if (M_AXIS_TVALID) begin
            chk("m_data", {M_AXIS_TLAST, M_AXIS_TDATA},
                {(out_idx == NR-1), 24'b0, exp_res[out_idx]});
            if (out_idx == 0 && !prev_valid) first_valid_cyc = cyc;
         end
         if (hs_out && busy) begin
            chk("out_spacing", (cyc - last_out_hs) >= 3, 1);
            last_out_hs = cyc;
            got_d.push_back(M_AXIS_TDATA);
            got_l.push_back(M_AXIS_TLAST);
            if (out_idx == NR-1) begin busy = 0; out_idx = 0; end
            else out_idx++;
         end
         prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
         prev_valid = M_AXIS_TVALID;
         prev_data  = M_AXIS_TDATA;
         prev_last  = M_AXIS_TLAST;

         if (hs_in) begin
            if (acc_cnt < NA)
               chk("wr_a", {A_write_en, B_write_en, A_write_address, A_write_data_in},
                   {1'b1, 1'b0, 3'(acc_cnt), S_AXIS_TDATA[7:0]});
            else
               chk("wr_b", {A_write_en, B_write_en, B_write_address, B_write_data_in},
                   {1'b0, 1'b1, 2'(acc_cnt - NA), S_AXIS_TDATA[7:0]});
            fin = (acc_cnt == NT-1);
`ifdef TLAST_CHECK_EN
            if (!fin && S_AXIS_TLAST) begin
               exp_ferr = 1; acc_cnt = -1;
            end
            if (fin && !S_AXIS_TLAST) exp_ferr = 1;
`endif
            if (fin) begin
               acc_cnt = 0; busy = 1; start_due = 1; out_idx = 0;
               exp_res = res_ram; final_hs_cyc = cyc;
            end else acc_cnt++;
         end else begin
            chk("no_write", {A_write_en, B_write_en}, 0);
         end
      end
   end

   // ---------------- output-side ready driver ----------------
   int rmode = 0;
   int stall_left = 0;

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: M_AXIS_TREADY = 1'b1;
            1: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            default: begin
               M_AXIS_TREADY = (stall_left == 0);
               if (M_AXIS_TVALID && stall_left > 0) stall_left--;
            end
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] frame_w [NT];

   task automatic wait_hs(output bit ok);
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (S_AXIS_TVALID && S_AXIS_TREADY) ok = 1;
         @(posedge clk); #1;
      end
      chk("in_handshake", ok, 1);
   endtask

   task automatic send_frame(input int n, input int tl, input int vmode, input bit hold);
      bit ok;
      for (int i = 0; i < n; i++) begin
         int gap;
         logic [31:0] d;
         gap = (vmode == 1) ? 1 : ((vmode == 2) ? int'($urandom_range(0, 2)) : 0);
         if (gap > 0) begin
            S_AXIS_TVALID = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         d = $urandom;
         d[7:0] = frame_w[i];
         S_AXIS_TDATA  = d;
         S_AXIS_TLAST  = (i == tl);
         S_AXIS_TVALID = 1'b1;
         wait_hs(ok);
         if (!ok) break;
      end
      if (!hold) begin
         S_AXIS_TVALID = 1'b0;
         S_AXIS_TLAST  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int t = 0; t < 400 && !idle; t++) begin
         @(posedge clk); #1;
         if (!busy) idle = 1;
      end
      chk("frame_complete", idle, 1);
   endtask

   task automatic check_rams();
      for (int i = 0; i < NA; i++) chk("a_ram", a_ram[i], frame_w[i]);
      for (int j = 0; j < NB; j++) chk("b_ram", b_ram[j], frame_w[NA+j]);
   endtask

   task automatic check_results();
      chk("result_count", got_d.size(), NR);
      for (int i = 0; i < NR && i < got_d.size(); i++) begin
         chk("result_data", got_d[i], {24'b0, res_ram[i]});
         chk("result_last", got_l[i], (i == NR-1));
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < NT; i++) frame_w[i] = 8'($urandom);
      for (int i = 0; i < NR; i++) res_ram[i] = 8'($urandom);
   endtask

   task automatic run_frame(input int vmode);
      got_d.delete(); got_l.delete();
      send_frame(NT, NT-1, vmode, 0);
      wait_idle();
      check_rams();
      check_results();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int sc;
      bit ok;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("tready_after_reset", S_AXIS_TREADY, 1);

      // Load 12 x 0x10, results {0x04, 0xA5}
      for (int i = 0; i < NT; i++) frame_w[i] = 8'h10;
      res_ram[0] = 8'h04; res_ram[1] = 8'hA5;
      rmode = 0;
      run_frame(0);
      for (int i = 0; i < NA; i++) chk("load_a_0x10", a_ram[i], 8'h10);
      for (int j = 0; j < NB; j++) chk("load_b_0x10", b_ram[j], 8'h10);
      chk("out0_data", got_d.size() > 0 ? got_d[0] : 32'hDEAD, 32'h0000_0004);
      chk("out0_last", got_l.size() > 0 ? got_l[0] : 1'b1, 0);
      chk("out1_data", got_d.size() > 1 ? got_d[1] : 32'hDEAD, 32'h0000_00A5);
      chk("out1_last", got_l.size() > 1 ? got_l[1] : 1'b0, 1);
      chk("start_latency", start_cyc - final_hs_cyc, 1);
      chk("first_valid_latency", first_valid_cyc - start_cyc, 13);
      chk("back_to_idle_tready", S_AXIS_TREADY, 1);

      // Reset in the middle of loading, then a clean frame from address 0
      rand_frame();
      send_frame(5, NT-1, 0, 0);
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      rand_frame();
      run_frame(0);
      chk("after_reset_a0", a_ram[0], frame_w[0]);

      // Input toggling and a 7-cycle stall on result 0
      rand_frame();
      rmode = 2; stall_left = 7;
      run_frame(1);
      chk("stall_consumed", stall_left, 0);

      // Lockout: TVALID held high through compute and send
      rand_frame();
      rmode = 0;
      got_d.delete(); got_l.delete();
      send_frame(NT, NT-1, 0, 1);
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(posedge clk); #1;
         if (M_AXIS_TVALID && M_AXIS_TLAST) ok = 1;
      end
      chk("lockout_last_seen", ok, 1);
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
      wait_idle();
      check_rams();
      check_results();

      // Stray Done while idle is ignored; Done in the Start cycle is honoured
      sc = n_starts;
      @(posedge clk); #1 spur = 1'b1;
      @(posedge clk); #1 spur = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("stray_done_no_start", n_starts, sc);
      chk("stray_done_no_valid", M_AXIS_TVALID, 0);
      rand_frame();
      done_now = 1'b1;
      run_frame(2);
      chk("done_same_cycle_latency", first_valid_cyc - start_cyc, 3);
      done_now = 1'b0;
      repeat (12) @(posedge clk); #1;

      // Randomized frames
      for (int k = 0; k < 8; k++) begin
         rand_frame();
         rmode = $urandom_range(0, 1);
         done_now = 1'($urandom_range(0, 1));
         run_frame($urandom_range(0, 2));
         done_now = 1'b0;
         repeat (12) @(posedge clk); #1;
      end
      rmode = 0;

`ifdef TLAST_CHECK_EN
      // Early TLAST aborts the frame; the next full frame still completes
      rand_frame();
      sc = n_starts;
      send_frame(6, 5, 0, 0);
      repeat (15) @(posedge clk); #1;
      chk("abort_no_start", n_starts, sc);
      chk("abort_frame_err", frame_err, 1);
      rand_frame();
      run_frame(0);
      chk("frame_err_sticky", frame_err, 1);
`else
      // TLAST on an early word has no effect on counting
      rand_frame();
      got_d.delete(); got_l.delete();
      send_frame(NT, 3, 0, 0);
      wait_idle();
      check_rams();
      check_results();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
